// File: rtl/nvr_pkg.sv
// rtl/nvr_pkg.sv - shared types, widths and default timing constants for the NVR controller
package nvr_pkg;
    localparam int NVR_ADDR_W      = 7;
    localparam int NVR_DATA_W      = 32;
    localparam int NVR_POR_CYC     = 8;
    localparam int NVR_RDY_SETUP   = 2;
    localparam int NVR_PULSE_CYC   = 4;
    localparam int NVR_TIMEOUT_CYC = 4096;

    typedef enum logic [2:0] {
        ST_POR,
        ST_RECALL_INIT,
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
        ST_WAIT_RDY,
        ST_RESP
    } nvr_state_e;

    typedef enum logic [1:0] {
        OP_BUS,
        OP_STORE,
        OP_RECALL
    } nvr_op_e;

    // Counter width large enough for the longest interval the shared timer must time.
    function automatic int nvr_cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction
endpackage

// File: rtl/nvr_rdy_timer.sv
// rtl/nvr_rdy_timer.sv - shared down-counter; expire_o is high on the last cycle of a loaded interval
module nvr_rdy_timer #(
    parameter int CNT_W   = 13,
    parameter int RST_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             expire_o
);
    logic [CNT_W-1:0] cnt_q;

    // Reset preloads the power-on interval so POR timing starts without a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_W'(RST_LEN - 1);
        end else if (load_i) begin
            cnt_q <= len_i - CNT_W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/nvr_ctrl.sv
// rtl/nvr_ctrl.sv - NVR macro sequencer (POR, power-up recall, word access, store/recall)
// Optional RDY timeout and sticky err flag enabled by defining NVR_TIMEOUT_EN.
module nvr_ctrl
    import nvr_pkg::*;
#(
    parameter int ADDR_W      = NVR_ADDR_W,
    parameter int DATA_W      = NVR_DATA_W,
    parameter int POR_CYC     = NVR_POR_CYC,
    parameter int RDY_SETUP   = NVR_RDY_SETUP,
    parameter int PULSE_CYC   = NVR_PULSE_CYC,
    parameter int TIMEOUT_CYC = NVR_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              store_req,
    input  logic              recall_req,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] nvr_a,
    output logic [DATA_W-1:0] nvr_din,
    output logic              nvr_ce,
    output logic              nvr_we,
    output logic              nvr_hs,
    output logic              nvr_hr,
    output logic              nvr_por,
    input  logic [DATA_W-1:0] nvr_dout,
    input  logic              nvr_rdy
);
    localparam int CNT_W = nvr_cnt_w(POR_CYC, PULSE_CYC, RDY_SETUP, TIMEOUT_CYC);

    nvr_state_e        state_q;
    nvr_op_e           op_q;
    logic              pend_rec_q, pend_sto_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] din_q, rdata_q;
    logic              wr_q, ce_q, we_pin_q, hs_q, hr_q, por_q, rsp_valid_q;
    logic              take_rec, take_sto, accept;
    logic              tmr_load, tmr_exp;
    logic [CNT_W-1:0]  tmr_len;

    assign req_ready = (state_q == ST_IDLE) && !pend_rec_q && !pend_sto_q;
    assign take_rec  = (state_q == ST_IDLE) && pend_rec_q;
    assign take_sto  = (state_q == ST_IDLE) && !pend_rec_q && pend_sto_q;
    assign accept    = req_ready && req_valid;

    nvr_rdy_timer #(
        .CNT_W  (CNT_W),
        .RST_LEN(POR_CYC)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .len_i   (tmr_len),
        .expire_o(tmr_exp)
    );

    // Timer is loaded on the edge that enters each timed state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_len  = CNT_W'(1);
        case (state_q)
            ST_RECALL_INIT: begin
                tmr_load = 1'b1;
                tmr_len  = CNT_W'(PULSE_CYC);
            end
            ST_IDLE: begin
                if (take_rec || take_sto) begin
                    tmr_load = 1'b1;
                    tmr_len  = CNT_W'(PULSE_CYC);
                end else if (accept) begin
                    tmr_load = 1'b1;
                end
            end
            ST_PULSE: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_len  = CNT_W'(RDY_SETUP);
                end
            end
`ifdef NVR_TIMEOUT_EN
            ST_SETTLE: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_len  = CNT_W'(TIMEOUT_CYC);
                end
            end
`endif
            default: ;
        endcase
    end

`ifdef NVR_TIMEOUT_EN
    logic err_q;
    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_POR;
            op_q        <= OP_RECALL;
            pend_rec_q  <= 1'b0;
            pend_sto_q  <= 1'b0;
            a_q         <= '0;
            din_q       <= '0;
            rdata_q     <= '0;
            wr_q        <= 1'b0;
            ce_q        <= 1'b0;
            we_pin_q    <= 1'b0;
            hs_q        <= 1'b0;
            hr_q        <= 1'b0;
            por_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
`ifdef NVR_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            // A pulse arriving on the dispatch cycle is a fresh command, so it survives the clear.
            pend_rec_q  <= (pend_rec_q && !take_rec) || recall_req;
            pend_sto_q  <= (pend_sto_q && !take_sto) || store_req;
            ce_q        <= 1'b0;
            we_pin_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef NVR_TIMEOUT_EN
            if (err_clr) err_q <= 1'b0;
`endif
            case (state_q)
                ST_POR: begin
                    if (tmr_exp) begin
                        por_q   <= 1'b0;
                        state_q <= ST_RECALL_INIT;
                    end
                end
                ST_RECALL_INIT: begin
                    hr_q    <= 1'b1;
                    op_q    <= OP_RECALL;
                    state_q <= ST_PULSE;
                end
                ST_IDLE: begin
                    if (take_rec) begin
                        hr_q    <= 1'b1;
                        op_q    <= OP_RECALL;
                        state_q <= ST_PULSE;
                    end else if (take_sto) begin
                        hs_q    <= 1'b1;
                        op_q    <= OP_STORE;
                        state_q <= ST_PULSE;
                    end else if (accept) begin
                        a_q      <= req_addr;
                        din_q    <= req_wdata;
                        wr_q     <= req_we;
                        ce_q     <= 1'b1;
                        we_pin_q <= req_we;
                        op_q     <= OP_BUS;
                        state_q  <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_exp) begin
                        hs_q    <= 1'b0;
                        hr_q    <= 1'b0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_exp) state_q <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (nvr_rdy) begin
                        if (op_q == OP_BUS) begin
                            if (!wr_q) rdata_q <= nvr_dout;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
`ifdef NVR_TIMEOUT_EN
                    else if (tmr_exp) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                        if (op_q == OP_BUS) begin
                            rdata_q     <= '0;
                            rsp_valid_q <= 1'b1;
                        end
                    end
`endif
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_POR;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE) || pend_rec_q || pend_sto_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign nvr_a     = a_q;
    assign nvr_din   = din_q;
    assign nvr_ce    = ce_q;
    assign nvr_we    = we_pin_q;
    assign nvr_hs    = hs_q;
    assign nvr_hr    = hr_q;
    assign nvr_por   = por_q;
endmodule

// File: tb/tb_nvr_ctrl.sv
// tb/tb_nvr_ctrl.sv - directed self-checking bench for nvr_ctrl (both NVR_TIMEOUT_EN builds)
module tb_nvr_ctrl;
    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        store_req, recall_req, busy, err, err_clr;
    logic [6:0]  nvr_a;
    logic [31:0] nvr_din, nvr_dout;
    logic        nvr_ce, nvr_we, nvr_hs, nvr_hr, nvr_por, nvr_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    int ce_n, ce_first, hs_n, hs_first, hr_n, hr_first, rsp_n, rsp_cyc, rdy_cyc, idle_cyc;
    logic        we_ce, din_ok;
    logic [6:0]  a_ce;
    logic [31:0] din_ce, rdata_rsp;

    nvr_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .store_req(store_req), .recall_req(recall_req),
        .busy(busy), .err(err), .err_clr(err_clr),
        .nvr_a(nvr_a), .nvr_din(nvr_din), .nvr_ce(nvr_ce), .nvr_we(nvr_we),
        .nvr_hs(nvr_hs), .nvr_hr(nvr_hr), .nvr_por(nvr_por),
        .nvr_dout(nvr_dout), .nvr_rdy(nvr_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_por"}, nvr_por, 1);
        chk({pfx, "_busy"}, busy, 1);
        chk({pfx, "_ready"}, req_ready, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_rdata"}, rsp_rdata, 0);
        chk({pfx, "_pins"}, {nvr_ce, nvr_we, nvr_hs, nvr_hr}, 0);
        chk({pfx, "_err"}, err, 0);
    endtask

    task automatic pwrup(input string pfx);
        int por_n, hrn, rspn, rdy_at;
        rst = 1'b1;
        nvr_rdy = 1'b1;
        step();
        step();
        chk_reset_vals(pfx);
        rst = 1'b0;
        por_n = 0; hrn = 0; rspn = 0; rdy_at = -1;
        for (int c = 0; c < 60 && rdy_at < 0; c++) begin
            por_n += int'(nvr_por);
            hrn   += int'(nvr_hr);
            rspn  += int'(rsp_valid);
            if (req_ready) rdy_at = c;
            step();
        end
        chk({pfx, "_por_cycles"}, por_n, 8);
        chk({pfx, "_hr_cycles"}, hrn, 4);
        chk({pfx, "_no_rsp"}, rspn, 0);
        chk({pfx, "_ready_at"}, rdy_at, 16);
    endtask

    // Cycle 0 is the cycle the caller presents the request; stats are relative to it.
    task automatic mon(input int ncyc, input int rdy_on, input int cmd_cyc, input logic [1:0] cmd);
        ce_n = 0; ce_first = -1; hs_n = 0; hs_first = -1; hr_n = 0; hr_first = -1;
        rsp_n = 0; rsp_cyc = -1; rdy_cyc = -1; idle_cyc = -1; din_ok = 1'b1;
        we_ce = 1'b0; a_ce = '0; din_ce = '0; rdata_rsp = '0;
        for (int c = 0; c < ncyc; c++) begin
            nvr_rdy    = (c >= rdy_on);
            store_req  = (c == cmd_cyc) && cmd[0];
            recall_req = (c == cmd_cyc) && cmd[1];
            if (c == 1) req_valid = 1'b0;
            if (nvr_ce) begin
                ce_n++;
                if (ce_first < 0) begin
                    ce_first = c; we_ce = nvr_we; a_ce = nvr_a; din_ce = nvr_din;
                end
            end
            if (ce_first >= 0 && rsp_cyc < 0 && nvr_din !== din_ce) din_ok = 1'b0;
            if (nvr_hs) begin hs_n++; if (hs_first < 0) hs_first = c; end
            if (nvr_hr) begin hr_n++; if (hr_first < 0) hr_first = c; end
            if (rsp_valid) begin
                rsp_n++;
                if (rsp_cyc < 0) begin rsp_cyc = c; rdata_rsp = rsp_rdata; end
            end
            if (c > 0 && req_ready && rdy_cyc < 0) rdy_cyc = c;
            if (c > 0 && !busy && idle_cyc < 0) idle_cyc = c;
            step();
        end
        store_req = 1'b0; recall_req = 1'b0; req_valid = 1'b0;
    endtask

    task automatic bus_req(input logic we, input logic [6:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        store_req = 1'b0; recall_req = 1'b0; err_clr = 1'b0;
        nvr_dout = '0; nvr_rdy = 1'b1;

        pwrup("pu");

        nvr_dout = 32'hDEADBEEF;
        chk("rd_ready", req_ready, 1);
        bus_req(1'b0, 7'h05, 32'h0);
        mon(12, 0, -1, 2'b00);
        chk("rd_ce_n", ce_n, 1);
        chk("rd_ce_cyc", ce_first, 1);
        chk("rd_we", we_ce, 0);
        chk("rd_addr", a_ce, 32'h05);
        chk("rd_rsp_cyc", rsp_cyc, 5);
        chk("rd_rsp_n", rsp_n, 1);
        chk("rd_rdata", rdata_rsp, 32'hDEADBEEF);
        chk("rd_ready_back", rdy_cyc, 6);

        nvr_dout = 32'h0BADF00D;
        bus_req(1'b1, 7'h7F, 32'h12345678);
        mon(20, 12, -1, 2'b00);
        chk("wr_ce_n", ce_n, 1);
        chk("wr_we", we_ce, 1);
        chk("wr_addr", a_ce, 32'h7F);
        chk("wr_din", din_ce, 32'h12345678);
        chk("wr_din_stable", din_ok, 1);
        chk("wr_rsp_cyc", rsp_cyc, 13);
        chk("wr_rdata_kept", rdata_rsp, 32'hDEADBEEF);

        nvr_dout = 32'hA5A50001;
        bus_req(1'b0, 7'h03, 32'h0);
        mon(30, 0, 2, 2'b11);
        chk("fl_rsp_cyc", rsp_cyc, 5);
        chk("fl_rdata", rdata_rsp, 32'hA5A50001);
        chk("fl_hr_first", hr_first, 7);
        chk("fl_hr_n", hr_n, 4);
        chk("fl_hs_first", hs_first, 15);
        chk("fl_hs_n", hs_n, 4);
        chk("fl_idle", idle_cyc, 22);

        bus_req(1'b0, 7'h01, 32'h0);
        mon(20, 0, 0, 2'b01);
        chk("sb_rsp_cyc", rsp_cyc, 5);
        chk("sb_hs_first", hs_first, 7);
        chk("sb_idle", idle_cyc, 14);

        mon(14, 0, 0, 2'b01);
        chk("st_hs_first", hs_first, 2);
        chk("st_hs_n", hs_n, 4);
        chk("st_idle", idle_cyc, 9);
        chk("st_no_rsp", rsp_n, 0);
        chk("st_no_ce", ce_n, 0);

`ifdef NVR_TIMEOUT_EN
        bus_req(1'b0, 7'h02, 32'h0);
        mon(30, 1000, -1, 2'b00);
        chk("to_rsp_cyc", rsp_cyc, 20);
        chk("to_rdata", rdata_rsp, 0);
        chk("to_err", err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_err_clr", err, 0);
        bus_req(1'b0, 7'h02, 32'h0);
        mon(8, 1000, -1, 2'b00);
`else
        bus_req(1'b0, 7'h02, 32'h0);
        mon(40, 1000, -1, 2'b00);
        chk("hang_no_rsp", rsp_n, 0);
        chk("hang_busy", idle_cyc, -1);
        chk("hang_err", err, 0);
`endif

        rst = 1'b1;
        #1;
        chk_reset_vals("mid");
        pwrup("rp");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end
endmodule
